// File: rtl/mem_access_unit_if.sv
// Request, RAM-port and write-back bundle for mem_access_unit.
// Latency: none, this is wiring only.
// Backpressure: req_ready_o and stall_i travel here; the engine applies them.
interface mem_access_unit_if #(
  parameter int BUS_BYTES = 1
);
  // pipeline side
  logic                   stall_i;
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_mem_i;
  logic                   req_we_i;
  logic [1:0]             req_size_i;
  logic                   req_signed_i;
  logic [31:0]            req_addr_i;
  logic [31:0]            req_wdata_i;
  logic                   req_wreg_i;
  logic [4:0]             req_waddr_i;
  // RAM arbiter side
  logic                   ram_re_o;
  logic                   ram_we_o;
  logic [31:0]            ram_addr_o;
  logic [BUS_BYTES-1:0]   ram_be_o;
  logic [8*BUS_BYTES-1:0] ram_wdata_o;
  logic [8*BUS_BYTES-1:0] ram_rdata_i;
  // status and MEM/WB side
  logic                   busy_o;
  logic                   wb_valid_o;
  logic                   wb_wreg_o;
  logic [4:0]             wb_waddr_o;
  logic [31:0]            wb_wdata_o;

  // engine view
  modport slave (
    input  stall_i, req_valid_i, req_mem_i, req_we_i, req_size_i, req_signed_i,
           req_addr_i, req_wdata_i, req_wreg_i, req_waddr_i, ram_rdata_i,
    output req_ready_o, ram_re_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
           busy_o, wb_valid_o, wb_wreg_o, wb_waddr_o, wb_wdata_o
  );

  // pipeline/RAM environment view
  modport master (
    output stall_i, req_valid_i, req_mem_i, req_we_i, req_size_i, req_signed_i,
           req_addr_i, req_wdata_i, req_wreg_i, req_waddr_i, ram_rdata_i,
    input  req_ready_o, ram_re_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
           busy_o, wb_valid_o, wb_wreg_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage engine: one load/store/pass-through at a time, split into BUS_BYTES-wide RAM beats.
// Latency: pass-through 1 cycle, store 1+beats, load 1+beats*(RD_LAT+1) cycles to wb_valid_o.
// Backpressure: req_ready_o only in IDLE without stall; stall freezes beat issue and holds DONE.
module mem_access_unit #(
  parameter int BUS_BYTES = 1,
  parameter int RD_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int LW = 8 * BUS_BYTES;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_BEAT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // latched request
  logic        r_mem;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wreg;
  logic [4:0]  r_waddr;

  // beat bookkeeping and load assembly
  logic [1:0]  r_beat;
  logic [2:0]  r_cnt;
  logic [31:0] r_res;

  logic [2:0]    w_nbytes;
  logic [1:0]    w_last_beat;
  logic          w_is_last;
  logic          w_accept;
  logic          w_capture;
  logic          w_ready;
  logic          w_re;
  logic          w_we;
  logic          w_wb_valid;
  logic [31:0]   w_beat_addr;
  logic [BUS_BYTES-1:0] w_lane_en;
  logic [LW-1:0] w_lane_wd;
  logic [31:0]   w_res_nxt;
  logic [1:0]    w_bi;
  logic [31:0]   w_load;
  logic [31:0]   w_wb_wdata;

  // Size decode: byte/half/word; size 3 behaves as word.
  always_comb begin
    case (r_size)
      2'd0:    w_nbytes = 3'd1;
      2'd1:    w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Index of the final beat = ceil(nbytes/BUS_BYTES) - 1.
  assign w_last_beat = 2'((32'(w_nbytes) + 32'(BUS_BYTES) - 32'd1) / 32'(BUS_BYTES) - 32'd1);
  assign w_is_last   = (r_beat == w_last_beat);
  assign w_beat_addr = r_addr + 32'(r_beat) * 32'(BUS_BYTES);
  assign w_accept    = (r_state == S_IDLE) && !bus.stall_i && bus.req_valid_i;
  assign w_capture   = (r_state == S_RD_WAIT) && (r_cnt == 3'(RD_LAT));

  // Per-lane enables, store lane data and read-lane merge into the result word.
  always_comb begin
    w_lane_en = '0;
    w_lane_wd = '0;
    w_res_nxt = r_res;
    w_bi      = 2'd0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      if (32'(r_beat) * 32'(BUS_BYTES) + 32'(j) < 32'(w_nbytes)) begin
        w_bi                 = 2'(32'(r_beat) * 32'(BUS_BYTES) + 32'(j));
        w_lane_en[j]         = 1'b1;
        w_lane_wd[8*j +: 8]  = r_wdata[8*w_bi +: 8];
        w_res_nxt[8*w_bi +: 8] = bus.ram_rdata_i[8*j +: 8];
      end
    end
  end

  // Load result extension above the accessed width.
  always_comb begin
    case (r_size)
      2'd0:    w_load = {{24{r_signed & r_res[7]}},  r_res[7:0]};
      2'd1:    w_load = {{16{r_signed & r_res[15]}}, r_res[15:0]};
      default: w_load = r_res;
    endcase
  end

  // Write-back value: ALU result for pass-through, zero for stores, extended data for loads.
  always_comb begin
    if (!r_mem) begin
      w_wb_wdata = r_addr;
    end else if (r_we) begin
      w_wb_wdata = 32'd0;
    end else begin
      w_wb_wdata = w_load;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode; stall only blocks new beats, never an in-flight read.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_re        = 1'b0;
    w_we        = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = !bus.stall_i;
        if (w_accept) begin
          if (!bus.req_mem_i) begin
            w_state_nxt = S_DONE;
          end else if (bus.req_we_i) begin
            w_state_nxt = S_WR_BEAT;
          end else begin
            w_state_nxt = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: begin
        if (!bus.stall_i) begin
          w_re        = 1'b1;
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_capture) begin
          w_state_nxt = w_is_last ? S_DONE : S_RD_ISSUE;
        end
      end
      S_WR_BEAT: begin
        if (!bus.stall_i) begin
          w_we = 1'b1;
          if (w_is_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_wb_valid = 1'b1;
        if (!bus.stall_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, beat counter, read-latency counter and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_wreg   <= 1'b0;
      r_waddr  <= 5'd0;
      r_beat   <= 2'd0;
      r_cnt    <= 3'd0;
      r_res    <= 32'd0;
    end else begin
      if (w_accept) begin
        r_mem    <= bus.req_mem_i;
        r_we     <= bus.req_we_i;
        r_size   <= bus.req_size_i;
        r_signed <= bus.req_signed_i;
        r_addr   <= bus.req_addr_i;
        r_wdata  <= bus.req_wdata_i;
        r_wreg   <= bus.req_wreg_i;
        r_waddr  <= bus.req_waddr_i;
        r_beat   <= 2'd0;
        r_cnt    <= 3'd0;
        r_res    <= 32'd0;
      end
      // the cycle after a read strobe is the first cycle of latency
      if (w_re) begin
        r_cnt <= 3'd1;
      end
      if (r_state == S_RD_WAIT) begin
        if (w_capture) begin
          r_res  <= w_res_nxt;
          r_beat <= r_beat + 2'd1;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
      if (w_we) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  // RAM port: address/enables/data are forced to zero whenever no strobe is active.
  assign bus.ram_re_o    = w_re;
  assign bus.ram_we_o    = w_we;
  assign bus.ram_addr_o  = (w_re || w_we) ? w_beat_addr : 32'd0;
  assign bus.ram_be_o    = (w_re || w_we) ? w_lane_en : '0;
  assign bus.ram_wdata_o = w_we ? w_lane_wd : '0;

  // Handshake, status and write-back; ready is masked while reset is held.
  assign bus.req_ready_o = w_ready && !rst;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.wb_valid_o  = w_wb_valid;
  assign bus.wb_wreg_o   = w_wb_valid && r_wreg && !(r_mem && r_we);
  assign bus.wb_waddr_o  = w_wb_valid ? r_waddr : 5'd0;
  assign bus.wb_wdata_o  = w_wb_valid ? w_wb_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (BUS_BYTES 1, 4, 2) sharing one byte RAM model.
// Stimulus pushes expected beats and write-back records; a negedge monitor pops and compares.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared request fields, per-instance valid
  logic        stall;
  logic        vld [3];
  logic        t_mem, t_we, t_signed, t_wreg;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  logic [4:0]  t_waddr;

  // 32-bit padded taps of every instance
  logic        rdy_a [3], re_a [3], we_a [3], busy_a [3], wbv_a [3], wbr_a [3];
  logic [31:0] addr_a [3], wd_a [3], rd_a [3], wbd_a [3];
  logic [3:0]  be_a [3];
  logic [4:0]  wba_a [3];

  mem_access_unit_if #(.BUS_BYTES(1)) if0 ();
  mem_access_unit_if #(.BUS_BYTES(4)) if1 ();
  mem_access_unit_if #(.BUS_BYTES(2)) if2 ();

  mem_access_unit #(.BUS_BYTES(1), .RD_LAT(2)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mem_access_unit #(.BUS_BYTES(4), .RD_LAT(2)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mem_access_unit #(.BUS_BYTES(2), .RD_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.stall_i = stall; assign if0.req_valid_i = vld[0]; assign if0.req_mem_i = t_mem;
  assign if0.req_we_i = t_we; assign if0.req_size_i = t_size; assign if0.req_signed_i = t_signed;
  assign if0.req_addr_i = t_addr; assign if0.req_wdata_i = t_wdata; assign if0.req_wreg_i = t_wreg;
  assign if0.req_waddr_i = t_waddr; assign if0.ram_rdata_i = rd_a[0][7:0];
  assign if1.stall_i = stall; assign if1.req_valid_i = vld[1]; assign if1.req_mem_i = t_mem;
  assign if1.req_we_i = t_we; assign if1.req_size_i = t_size; assign if1.req_signed_i = t_signed;
  assign if1.req_addr_i = t_addr; assign if1.req_wdata_i = t_wdata; assign if1.req_wreg_i = t_wreg;
  assign if1.req_waddr_i = t_waddr; assign if1.ram_rdata_i = rd_a[1];
  assign if2.stall_i = stall; assign if2.req_valid_i = vld[2]; assign if2.req_mem_i = t_mem;
  assign if2.req_we_i = t_we; assign if2.req_size_i = t_size; assign if2.req_signed_i = t_signed;
  assign if2.req_addr_i = t_addr; assign if2.req_wdata_i = t_wdata; assign if2.req_wreg_i = t_wreg;
  assign if2.req_waddr_i = t_waddr; assign if2.ram_rdata_i = rd_a[2][15:0];

  assign rdy_a[0] = if0.req_ready_o; assign re_a[0] = if0.ram_re_o; assign we_a[0] = if0.ram_we_o;
  assign addr_a[0] = if0.ram_addr_o; assign be_a[0] = {3'd0, if0.ram_be_o};
  assign wd_a[0] = {24'd0, if0.ram_wdata_o}; assign busy_a[0] = if0.busy_o;
  assign wbv_a[0] = if0.wb_valid_o; assign wbr_a[0] = if0.wb_wreg_o;
  assign wba_a[0] = if0.wb_waddr_o; assign wbd_a[0] = if0.wb_wdata_o;
  assign rdy_a[1] = if1.req_ready_o; assign re_a[1] = if1.ram_re_o; assign we_a[1] = if1.ram_we_o;
  assign addr_a[1] = if1.ram_addr_o; assign be_a[1] = if1.ram_be_o;
  assign wd_a[1] = if1.ram_wdata_o; assign busy_a[1] = if1.busy_o;
  assign wbv_a[1] = if1.wb_valid_o; assign wbr_a[1] = if1.wb_wreg_o;
  assign wba_a[1] = if1.wb_waddr_o; assign wbd_a[1] = if1.wb_wdata_o;
  assign rdy_a[2] = if2.req_ready_o; assign re_a[2] = if2.ram_re_o; assign we_a[2] = if2.ram_we_o;
  assign addr_a[2] = if2.ram_addr_o; assign be_a[2] = {2'd0, if2.ram_be_o};
  assign wd_a[2] = {16'd0, if2.ram_wdata_o}; assign busy_a[2] = if2.busy_o;
  assign wbv_a[2] = if2.wb_valid_o; assign wbr_a[2] = if2.wb_wreg_o;
  assign wba_a[2] = if2.wb_waddr_o; assign wbd_a[2] = if2.wb_wdata_o;

  // byte RAM with a fixed 2-cycle read pipeline per instance
  logic [7:0]  mem [0:4095];
  logic        p0v [3], p1v [3];
  logic [31:0] p0a [3], p1a [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      p0v[i] <= re_a[i];
      p0a[i] <= addr_a[i];
      p1v[i] <= p0v[i];
      p1a[i] <= p0a[i];
      if (we_a[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (be_a[i][j]) mem[12'(addr_a[i] + 32'(j))] = wd_a[i][8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_a[i] = 32'hEEEE_EEEE;
      if (p1v[i]) begin
        for (int j = 0; j < 4; j++) rd_a[i][8*j +: 8] = mem[12'(p1a[i] + 32'(j))];
      end
    end
  end

  // scoreboard
  typedef struct {
    int          inst;
    int          cyc;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    int          inst;
    int          first;
    int          last;
    bit          wreg;
    logic [4:0]  waddr;
    logic [31:0] wd;
  } wb_t;

  beat_t beat_q [$];
  wb_t   wb_q [$];
  beat_t mb;
  wb_t   mw;
  int    first_v [3] = '{-1, -1, -1};
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int inst, input int c, input bit wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.inst = inst; b.cyc = c; b.wr = wr; b.addr = a; b.be = be; b.wd = wd;
    beat_q.push_back(b);
  endtask

  task automatic push_wb(input int inst, input int f, input int l, input bit wr,
                         input logic [4:0] wa, input logic [31:0] wd);
    wb_t w;
    w.inst = inst; w.first = f; w.last = l; w.wreg = wr; w.waddr = wa; w.wd = wd;
    wb_q.push_back(w);
  endtask

  // monitor: RAM strobes and write-back records, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (re_a[i] || we_a[i]) begin
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: inst=%0d cycle=%0d addr=%h required=no beat", i, cyc, addr_a[i]);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_inst", 32'(i), 32'(mb.inst));
          chk("beat_cycle", 32'(cyc), 32'(mb.cyc));
          chk("beat_is_write", {31'd0, we_a[i]}, {31'd0, mb.wr});
          chk("beat_addr", addr_a[i], mb.addr);
          chk("beat_be", {28'd0, be_a[i]}, {28'd0, mb.be});
          if (mb.wr) chk("beat_wdata", wd_a[i], mb.wd);
        end
      end else begin
        chk("ram_idle_zero", addr_a[i] | wd_a[i] | {28'd0, be_a[i]}, 32'd0);
      end
      if (rst) begin
        first_v[i] = -1;
      end else if (wbv_a[i]) begin
        if (first_v[i] < 0) first_v[i] = cyc;
        if (!stall) begin
          if (wb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_wb: inst=%0d cycle=%0d wdata=%h required=no record", i, cyc, wbd_a[i]);
          end else begin
            mw = wb_q.pop_front();
            chk("wb_inst", 32'(i), 32'(mw.inst));
            chk("wb_first_cycle", 32'(first_v[i]), 32'(mw.first));
            chk("wb_last_cycle", 32'(cyc), 32'(mw.last));
            chk("wb_wreg", {31'd0, wbr_a[i]}, {31'd0, mw.wreg});
            chk("wb_waddr", {27'd0, wba_a[i]}, {27'd0, mw.waddr});
            chk("wb_wdata", wbd_a[i], mw.wd);
          end
          first_v[i] = -1;
        end
      end else begin
        chk("wb_idle_zero", {26'd0, wbr_a[i], wba_a[i]} | wbd_a[i], 32'd0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives one request for a single cycle; t = accept cycle
  task automatic issue(input int inst, input bit m, input bit w, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a, input logic [31:0] d,
                       input bit wr, input logic [4:0] wa, output int t);
    @(posedge clk);
    #1;
    t_mem = m; t_we = w; t_size = sz; t_signed = sg; t_addr = a; t_wdata = d;
    t_wreg = wr; t_waddr = wa; vld[inst] = 1'b1;
    t = cyc;
    @(negedge clk);
    chk("req_ready_on_accept", {31'd0, rdy_a[inst]}, 32'd1);
    @(posedge clk);
    #1;
    vld[inst] = 1'b0;
  endtask

  int t;

  initial begin
    rst = 1'b1; stall = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
    t_mem = 1'b0; t_we = 1'b0; t_size = 2'd0; t_signed = 1'b0;
    t_addr = 32'd0; t_wdata = 32'd0; t_wreg = 1'b0; t_waddr = 5'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h80;
    mem[12'h200] = 8'h11; mem[12'h201] = 8'h22; mem[12'h202] = 8'h33; mem[12'h203] = 8'h44;
    mem[12'h300] = 8'hA1; mem[12'h301] = 8'hB2; mem[12'h302] = 8'hC3; mem[12'h303] = 8'hD4;

    // reset state
    cycles(3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", {31'd0, rdy_a[i]}, 32'd0);
      chk("rst_busy", {31'd0, busy_a[i]}, 32'd0);
      chk("rst_wb_valid", {31'd0, wbv_a[i]}, 32'd0);
    end
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_after_rst", {31'd0, rdy_a[i]}, 32'd1);

    // signed byte load, BUS_BYTES=1
    issue(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h100, 32'd0, 1'b1, 5'd3, t);
    push_beat(0, t + 1, 1'b0, 32'h100, 4'b0001, 32'd0);
    push_wb(0, t + 4, t + 4, 1'b1, 5'd3, 32'hFFFF_FF80);
    cycles(6);

    // unsigned word load, BUS_BYTES=1: four beats three cycles apart
    issue(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b1, 5'd7, t);
    for (int k = 0; k < 4; k++) push_beat(0, t + 1 + 3 * k, 1'b0, 32'h200 + 32'(k), 4'b0001, 32'd0);
    push_wb(0, t + 13, t + 13, 1'b1, 5'd7, 32'h4433_2211);
    cycles(15);

    // unaligned half store, BUS_BYTES=4
    issue(1, 1'b1, 1'b1, 2'd1, 1'b0, 32'h3FE, 32'hABCD_1234, 1'b1, 5'd9, t);
    push_beat(1, t + 1, 1'b1, 32'h3FE, 4'b0011, 32'h0000_1234);
    push_wb(1, t + 2, t + 2, 1'b0, 5'd9, 32'd0);
    cycles(4);
    chk("mem_3fe", {24'd0, mem[12'h3FE]}, 32'h34);
    chk("mem_3ff", {24'd0, mem[12'h3FF]}, 32'h12);
    chk("mem_400_untouched", {24'd0, mem[12'h400]}, 32'h00);

    // word load, BUS_BYTES=2, stall T+2..T+4 and again in DONE for T+8..T+9
    issue(2, 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 1'b1, 5'd12, t);
    push_beat(2, t + 1, 1'b0, 32'h300, 4'b0011, 32'd0);
    push_beat(2, t + 5, 1'b0, 32'h302, 4'b0011, 32'd0);
    push_wb(2, t + 8, t + 10, 1'b1, 5'd12, 32'hD4C3_B2A1);
    cycles(1);
    stall = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("busy_while_stalled", {31'd0, busy_a[2]}, 32'd1);
    cycles(1);
    stall = 1'b0;
    cycles(3);
    stall = 1'b1;
    @(negedge clk);
    chk("wb_held_in_stall", {31'd0, wbv_a[2]}, 32'd1);
    cycles(2);
    stall = 1'b0;
    cycles(3);

    // request under stall is refused
    stall = 1'b1; t_mem = 1'b0; t_addr = 32'h1234; vld[0] = 1'b1;
    @(negedge clk);
    chk("ready_low_under_stall", {31'd0, rdy_a[0]}, 32'd0);
    cycles(1);
    vld[0] = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("not_accepted_under_stall", {31'd0, busy_a[0]}, 32'd0);

    // pass-through
    issue(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 5'd5, t);
    push_wb(0, t + 1, t + 1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycles(3);

    // word store, BUS_BYTES=1, reset after two beats
    issue(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h400, 32'h5566_7788, 1'b1, 5'd2, t);
    push_beat(0, t + 1, 1'b1, 32'h400, 4'b0001, 32'h88);
    push_beat(0, t + 2, 1'b1, 32'h401, 4'b0001, 32'h77);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy_a[0]}, 32'd0);
    chk("rst_mid_strobes", {30'd0, re_a[0], we_a[0]}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy_a[0]}, 32'd0);
    chk("rst_mid_wb", {31'd0, wbv_a[0]}, 32'd0);
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", {31'd0, rdy_a[0]}, 32'd1);
    chk("mem_400", {24'd0, mem[12'h400]}, 32'h88);
    chk("mem_401", {24'd0, mem[12'h401]}, 32'h77);
    chk("mem_402_not_written", {24'd0, mem[12'h402]}, 32'h00);

    cycles(3);
    chk("beats_outstanding", 32'(beat_q.size()), 32'd0);
    chk("wb_outstanding", 32'(wb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
